// File: rtl/dvp_sensor_tx.sv
// rtl/dvp_sensor_tx.sv - DVP camera-side transmitter producing RGB565 test patterns.
// Frame FSM drives registered vsync/href/data; pixel bytes are MSB first.
module dvp_sensor_tx #(
    parameter int H_ACT    = 1280,
    parameter int V_ACT    = 720,
    parameter int H_BLANK  = 200,
    parameter int VS_LINES = 4,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [1:0]  pattern_sel_i,
    output logic        dvp_vsync_o,
    output logic        dvp_href_o,
    output logic [7:0]  dvp_data_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int L     = 2 * H_ACT + H_BLANK;
    localparam int HW    = $clog2(L);
    localparam int BAR_W = H_ACT / 8;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [HW-1:0]  H_LAST    = HW'(L - 1);
    localparam logic [HW-1:0]  H_ACT_END = HW'(2 * H_ACT);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BAR_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  h_q, h_d;
    logic [15:0]    v_q, v_d;
    logic [2:0]     bar_q, bar_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [1:0]     pat_q, pat_d;
    logic [15:0]    fc_q, fc_d;
    logic [15:0]    fcnt_q, fcnt_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     data_q, data_d;
    logic           done_q, done_d;

    state_t      first_st;
    logic [15:0] lines;
    logic        line_end, phase_end, frame_end;
    logic [15:0] x_w, pix;

    function automatic logic [15:0] bar_color(input logic [2:0] b);
        case (b)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        bar_d     = bar_q;
        bcnt_d    = bcnt_q;
        pat_d     = pat_q;
        fc_d      = fc_q;
        fcnt_d    = fcnt_q;
        frame_end = 1'b0;

        // Empty leading phases are skipped so the first frame clock lands in a non-empty state.
        if (VS_LINES > 0)    first_st = S_VSYNC;
        else if (V_BACK > 0) first_st = S_VBACK;
        else                 first_st = S_ACTIVE;

        case (state_q)
            S_VSYNC:  lines = 16'(VS_LINES);
            S_VBACK:  lines = 16'(V_BACK);
            S_ACTIVE: lines = 16'(V_ACT);
            S_VFRONT: lines = 16'(V_FRONT);
            default:  lines = 16'd0;
        endcase
        line_end  = (h_q == H_LAST);
        phase_end = line_end && (v_q == lines - 16'd1);

        if (state_q == S_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (en_i) begin
                state_d = first_st;
                pat_d   = pattern_sel_i;
                fc_d    = fcnt_q;
            end
        end else begin
            h_d = line_end ? '0 : h_q + HW'(1);
            v_d = line_end ? (phase_end ? 16'd0 : v_q + 16'd1) : v_q;
            if (phase_end) begin
                case (state_q)
                    S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: begin
                        if (V_FRONT > 0) state_d = S_VFRONT;
                        else             frame_end = 1'b1;
                    end
                    S_VFRONT: frame_end = 1'b1;
                    default:  state_d = S_IDLE;
                endcase
            end
            if (frame_end) begin
                fcnt_d = fcnt_q + 16'd1;
                if (en_i) begin
                    state_d = first_st;
                    pat_d   = pattern_sel_i;
                    fc_d    = fcnt_q + 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end

        // Bar index advances after every BAR_W pixels; cleared at each line start.
        if (line_end || state_q != S_ACTIVE) begin
            bar_d  = 3'd0;
            bcnt_d = '0;
        end else if (h_q[0]) begin
            if (bcnt_q == BC_LAST) begin
                bcnt_d = '0;
                bar_d  = bar_q + 3'd1;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end

        x_w = 16'(h_q >> 1);
        case (pat_q)
            2'd0:    pix = bar_color(bar_q);
            2'd1:    pix = x_w;
            2'd2:    pix = (x_w[5] ^ v_q[5]) ? 16'hFFFF : 16'h0000;
            default: pix = fc_q;
        endcase

        vsync_d = (state_q == S_VSYNC);
        href_d  = (state_q == S_ACTIVE) && (h_q < H_ACT_END);
        data_d  = href_d ? (h_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        done_d  = frame_end;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            bar_q   <= '0;
            bcnt_q  <= '0;
            pat_q   <= '0;
            fc_q    <= '0;
            fcnt_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            bar_q   <= bar_d;
            bcnt_q  <= bcnt_d;
            pat_q   <= pat_d;
            fc_q    <= fc_d;
            fcnt_q  <= fcnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign dvp_vsync_o  = vsync_q;
    assign dvp_href_o   = href_q;
    assign dvp_data_o   = data_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_dvp_sensor_tx.sv
// tb/tb_dvp_sensor_tx.sv - scoreboard bench for dvp_sensor_tx.
module tb_dvp_sensor_tx;

    localparam int HA  = 8,  VA  = 4, HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int L   = 2 * HA + HB;
    localparam int FR  = (VS + VB + VA + VF) * L;
    localparam int HA2 = 64, VA2 = 2;
    localparam int L2  = 2 * HA2 + HB;
    localparam int FR2 = (VS + VB + VA2 + VF) * L2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, en2 = 1'b0;
    logic [1:0]  sel = 2'd0, sel2 = 2'd0;
    logic        vs, hr, done, vs2, hr2, done2;
    logic [7:0]  dat, dat2;
    logic [15:0] fcnt, fcnt2;

    always #5 clk = ~clk;

    dvp_sensor_tx #(.H_ACT(HA), .V_ACT(VA), .H_BLANK(HB), .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pattern_sel_i(sel),
        .dvp_vsync_o(vs), .dvp_href_o(hr), .dvp_data_o(dat),
        .frame_done_o(done), .frame_cnt_o(fcnt)
    );

    dvp_sensor_tx #(.H_ACT(HA2), .V_ACT(VA2), .H_BLANK(HB), .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) u_dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en2), .pattern_sel_i(sel2),
        .dvp_vsync_o(vs2), .dvp_href_o(hr2), .dvp_data_o(dat2),
        .frame_done_o(done2), .frame_cnt_o(fcnt2)
    );

    logic [7:0] q8[$];
    logic [7:0] q64[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int underrun = 0, idle_bad = 0, quiet_bad = 0;
    int n_href = 0, n_done = 0, n_done2 = 0;
    int vs_rise1, vs_rise2, vs_fall1, hr_rise1, hr_fall1, done1;
    logic vs_p = 1'b0, hr_p = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pix_model(input int pat, input int ha, input int x, input int y,
                                              input logic [15:0] fc);
        case (pat)
            0: begin
                case (x / (ha / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1: return 16'(x);
            2: return (((x >> 5) & 1) != ((y >> 5) & 1)) ? 16'hFFFF : 16'h0000;
            default: return fc;
        endcase
    endfunction

    task automatic push_frame(input int which, input int pat, input logic [15:0] fc);
        int ha = (which == 0) ? HA : HA2;
        int va = (which == 0) ? VA : VA2;
        logic [15:0] p;
        for (int y = 0; y < va; y++) begin
            for (int x = 0; x < ha; x++) begin
                p = pix_model(pat, ha, x, y, fc);
                if (which == 0) begin q8.push_back(p[15:8]);  q8.push_back(p[7:0]);  end
                else            begin q64.push_back(p[15:8]); q64.push_back(p[7:0]); end
            end
        end
    endtask

    task automatic clear_marks();
        vs_rise1 = -1; vs_rise2 = -1; vs_fall1 = -1;
        hr_rise1 = -1; hr_fall1 = -1; done1 = -1;
    endtask

    // One clock step: sample outputs on the falling edge and feed the scoreboards.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (hr) begin
            if (q8.size() == 0) underrun++;
            else check_eq("byte8", 32'(dat), 32'(q8.pop_front()));
        end
        if (hr2) begin
            if (q64.size() == 0) underrun++;
            else check_eq("byte64", 32'(dat2), 32'(q64.pop_front()));
        end
        if ((!hr && dat != 8'h00) || (!hr2 && dat2 != 8'h00)) idle_bad++;
        if (vs && !vs_p) begin
            if (vs_rise1 < 0)      vs_rise1 = cyc;
            else if (vs_rise2 < 0) vs_rise2 = cyc;
        end
        if (!vs && vs_p && vs_fall1 < 0) vs_fall1 = cyc;
        if (hr && !hr_p) begin
            n_href++;
            if (hr_rise1 < 0) hr_rise1 = cyc;
        end
        if (!hr && hr_p && hr_fall1 < 0) hr_fall1 = cyc;
        if (done) begin
            n_done++;
            if (done1 < 0) done1 = cyc;
        end
        if (done2) n_done2++;
        vs_p = vs;
        hr_p = hr;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic quiet_window(input string tag);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vs || hr || done || dat != 8'h00) bad++;
        end
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int e, d0, h0, r, t;
        clear_marks();
        tick(); tick(); tick();
        check_eq("reset_outputs", 32'({vs, hr, dat, done, fcnt}), 32'd0);
        rst_n = 1'b1;

        // Timing of the first frame, then bars -> checker -> solid with en dropped mid-frame.
        run_to(9);
        en = 1'b1; sel = 2'd0; e = cyc + 1;
        push_frame(0, 0, 16'd0);
        h0 = n_href; d0 = n_done;
        run_to(e + FR + 1);
        check_eq("vsync_rise", 32'(vs_rise1), 32'(e + 1));
        check_eq("vsync_fall", 32'(vs_fall1), 32'(e + VS * L + 1));
        check_eq("href_first", 32'(hr_rise1), 32'(e + (VS + VB) * L + 1));
        check_eq("href_end", 32'(hr_fall1), 32'(e + (VS + VB) * L + 1 + 2 * HA));
        check_eq("href_count", 32'(n_href - h0), 32'(VA));
        check_eq("done_edge", 32'(done1), 32'(e + FR));
        check_eq("vsync_rerise", 32'(vs_rise2), 32'(e + FR + 1));
        check_eq("frame_cnt_1", 32'(fcnt), 32'd1);
        push_frame(0, 0, 16'd1);
        run_to(e + FR + 60);
        sel = 2'd2;
        push_frame(0, 2, 16'd2);
        run_to(e + 2 * FR + 60);
        sel = 2'd3;
        push_frame(0, 3, 16'd3);
        run_to(e + 3 * FR + 20);
        en = 1'b0;
        run_to(e + 4 * FR + 1);
        check_eq("frame_cnt_4", 32'(fcnt), 32'd4);
        check_eq("done_count_4", 32'(n_done - d0), 32'd4);
        check_eq("q8_left_a", 32'(q8.size()), 32'd0);
        quiet_window("idle_quiet_a");

        // Solid pattern over three frames: each carries its own frame number.
        do_reset();
        sel = 2'd3; en = 1'b1; e = cyc + 1; d0 = n_done;
        push_frame(0, 3, 16'd0);
        push_frame(0, 3, 16'd1);
        push_frame(0, 3, 16'd2);
        run_to(e + 2 * FR + 10);
        en = 1'b0;
        run_to(e + 3 * FR + 5);
        check_eq("frame_cnt_3", 32'(fcnt), 32'd3);
        check_eq("done_count_3", 32'(n_done - d0), 32'd3);
        check_eq("q8_left_b", 32'(q8.size()), 32'd0);

        // Ramp frame with en dropped during vsync: the frame still completes once.
        do_reset();
        clear_marks();
        sel = 2'd1; en = 1'b1; e = cyc + 1; d0 = n_done;
        push_frame(0, 1, 16'd0);
        repeat (5) tick();
        en = 1'b0;
        run_to(e + FR + 1);
        check_eq("drop_en_done", 32'(n_done - d0), 32'd1);
        check_eq("drop_en_edge", 32'(done1), 32'(e + FR));
        check_eq("drop_en_cnt", 32'(fcnt), 32'd1);
        check_eq("q8_left_c", 32'(q8.size()), 32'd0);
        quiet_window("idle_quiet_c");

        // Asynchronous reset while href is high, then restart from vsync.
        sel = 2'd0; en = 1'b1;
        push_frame(0, 0, 16'd1);
        t = 0;
        while (!hr && t < 3 * FR) begin tick(); t++; end
        check_eq("href_seen", 32'(hr), 32'd1);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", 32'({vs, hr, dat, done, fcnt}), 32'd0);
        q8.delete();
        tick(); tick();
        rst_n = 1'b1;
        r = cyc;
        clear_marks();
        push_frame(0, 0, 16'd0);
        check_eq("restart_cnt0", 32'(fcnt), 32'd0);
        tick(); tick(); tick();
        en = 1'b0;
        run_to(r + 1 + FR + 1);
        check_eq("restart_vsync", 32'(vs_rise1), 32'(r + 2));
        check_eq("restart_done", 32'(done1), 32'(r + 1 + FR));
        check_eq("restart_cnt1", 32'(fcnt), 32'd1);
        check_eq("q8_left_d", 32'(q8.size()), 32'd0);

        // Wide instance exercises the checker across x[5].
        d0 = n_done2;
        sel2 = 2'd2; en2 = 1'b1;
        push_frame(1, 2, 16'd0);
        tick(); tick(); tick();
        en2 = 1'b0;
        repeat (FR2 + 20) tick();
        check_eq("done64", 32'(n_done2 - d0), 32'd1);
        check_eq("q64_left", 32'(q64.size()), 32'd0);
        check_eq("frame_cnt64", 32'(fcnt2), 32'd1);

        check_eq("underrun", 32'(underrun), 32'd0);
        check_eq("idle_data_zero", 32'(idle_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
